// File: rtl/free_list_nw_if.sv
// Dispatch / retirement interface of the N-wide physical-register free list.
// The free list itself is the slave; the renaming/ROB side is the master.
interface free_list_nw_if #(
  parameter int TAG_W = 7,
  parameter int WIDTH = 2,
  parameter int DEPTH = 64
);
  localparam int NUM_W = $clog2(WIDTH + 1);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [NUM_W-1:0]       id_dispatch_num;
  logic                   fl_grant;
  logic [WIDTH*TAG_W-1:0] fl_pr;
  logic [WIDTH-1:0]       fl_pr_valid;
  logic [CNT_W-1:0]       fl_free_count;
  logic [NUM_W-1:0]       rob_retire_num;
  logic [WIDTH*TAG_W-1:0] rob_retire_tags;
  logic [NUM_W-1:0]       rob_commit_num;
  logic                   rob_recover;
  logic                   fl_overflow;

  modport master (
    output id_dispatch_num, rob_retire_num, rob_retire_tags, rob_commit_num, rob_recover,
    input  fl_grant, fl_pr, fl_pr_valid, fl_free_count, fl_overflow
  );

  modport slave (
    input  id_dispatch_num, rob_retire_num, rob_retire_tags, rob_commit_num, rob_recover,
    output fl_grant, fl_pr, fl_pr_valid, fl_free_count, fl_overflow
  );
endinterface

// File: rtl/free_list_nw.sv
// N-wide physical-register free list: circular buffer of free tags with
// all-or-nothing allocation, an architectural head for one-cycle mispredict
// recovery, and a sticky overflow flag. Pointers wrap at any DEPTH.
module free_list_nw #(
  parameter int NUM_AREGS = 32,
  parameter int NUM_PREGS = 96,
  parameter int TAG_W     = 7,
  parameter int WIDTH     = 2
) (
  input  logic          clock,
  input  logic          reset,
  free_list_nw_if.slave fl
);
  localparam int DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int CW    = CNT_W + 1;
  localparam int PW    = PTR_W + 1;

  localparam logic [CW-1:0]      DEPTH_C = CW'(DEPTH);
  localparam logic [PTR_W+1:0]   DEPTH_P = (PTR_W + 2)'(DEPTH);

  logic [TAG_W-1:0] entry_q [DEPTH];
  logic [TAG_W-1:0] entry_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] arch_head_q, arch_head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] arch_count_q, arch_count_d;
  logic             overflow_q, overflow_d;

  logic                   grant;
  logic [WIDTH*TAG_W-1:0] pr;
  logic [WIDTH-1:0]       pr_valid;

  // Modular pointer addition; k never exceeds WIDTH so one subtraction suffices
  // and non-power-of-two depths wrap correctly.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [PW-1:0]    k);
    logic [PTR_W+1:0] s;
    s = {2'b00, p} + {1'b0, k};
    if (s >= DEPTH_P) s = s - DEPTH_P;
    return s[PTR_W-1:0];
  endfunction

  // Allocation outputs and next state: free, then commit, then allocate/recover.
  always_comb begin
    logic [CW-1:0] cnt_ext, arch_ext, n_ext, m_ext, c_ext, n_g, room, m_acc, arch_nxt;

    entry_d      = entry_q;
    head_d       = head_q;
    arch_head_d  = arch_head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    arch_count_d = arch_count_q;
    overflow_d   = overflow_q;
    pr           = '0;
    pr_valid     = '0;

    cnt_ext  = {1'b0, count_q};
    arch_ext = {1'b0, arch_count_q};
    n_ext    = CW'(fl.id_dispatch_num);
    m_ext    = CW'(fl.rob_retire_num);
    c_ext    = CW'(fl.rob_commit_num);

    grant = !fl.rob_recover && (n_ext <= cnt_ext);
    n_g   = grant ? n_ext : '0;

    for (int k = 0; k < WIDTH; k++) begin
      if (grant && (CW'(k) < n_ext)) begin
        pr[k*TAG_W +: TAG_W] = entry_q[ptr_add(head_q, PW'(k))];
        pr_valid[k]          = 1'b1;
      end
    end

    // Raw request overflowing either view is an error; only what fits is pushed.
    if ((cnt_ext + m_ext - n_g > DEPTH_C) || (arch_ext + m_ext - c_ext > DEPTH_C))
      overflow_d = 1'b1;

    // The architectural window after commit bounds the ring occupancy.
    room  = DEPTH_C + c_ext - arch_ext;
    m_acc = (m_ext < room) ? m_ext : room;

    for (int k = 0; k < WIDTH; k++) begin
      if (CW'(k) < m_acc)
        entry_d[ptr_add(tail_q, PW'(k))] = fl.rob_retire_tags[k*TAG_W +: TAG_W];
    end
    tail_d = ptr_add(tail_q, PW'(m_acc));

    arch_nxt     = arch_ext + m_acc - c_ext;
    arch_count_d = CNT_W'(arch_nxt);
    arch_head_d  = ptr_add(arch_head_q, PW'(c_ext));

    if (fl.rob_recover) begin
      head_d  = arch_head_d;
      count_d = CNT_W'(arch_nxt);
    end else begin
      head_d  = ptr_add(head_q, PW'(n_g));
      count_d = CNT_W'(cnt_ext + m_acc - n_g);
    end
  end

  // State registers; the entry array carries the initial tag image on reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) entry_q[i] <= TAG_W'(NUM_AREGS + i);
      head_q       <= '0;
      arch_head_q  <= '0;
      tail_q       <= '0;
      count_q      <= CNT_W'(DEPTH);
      arch_count_q <= CNT_W'(DEPTH);
      overflow_q   <= 1'b0;
    end else begin
      entry_q      <= entry_d;
      head_q       <= head_d;
      arch_head_q  <= arch_head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      arch_count_q <= arch_count_d;
      overflow_q   <= overflow_d;
    end
  end

  assign fl.fl_grant      = grant;
  assign fl.fl_pr         = pr;
  assign fl.fl_pr_valid   = pr_valid;
  assign fl.fl_free_count = count_q;
  assign fl.fl_overflow   = overflow_q;
endmodule

// File: tb/tb_free_list_nw.sv
// Bench for free_list_nw: a DEPTH=64 and a DEPTH=63 instance share one
// stimulus stream and are compared each cycle against a queue-based model,
// with extra directed checks on the DEPTH=64 instance.
module tb_free_list_nw;
  localparam int TAG_W     = 7;
  localparam int WIDTH     = 2;
  localparam int NUM_AREGS = 32;
  localparam int NUM_W     = $clog2(WIDTH + 1);

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  free_list_nw_if #(.TAG_W(TAG_W), .WIDTH(WIDTH), .DEPTH(64)) ifa ();
  free_list_nw_if #(.TAG_W(TAG_W), .WIDTH(WIDTH), .DEPTH(63)) ifb ();

  free_list_nw #(.NUM_AREGS(NUM_AREGS), .NUM_PREGS(96), .TAG_W(TAG_W), .WIDTH(WIDTH))
    dut_a (.clock(clock), .reset(reset), .fl(ifa));
  free_list_nw #(.NUM_AREGS(NUM_AREGS), .NUM_PREGS(95), .TAG_W(TAG_W), .WIDTH(WIDTH))
    dut_b (.clock(clock), .reset(reset), .fl(ifb));

  int tests = 0;
  int fails = 0;

  // Model: aqX holds every tag from the architectural head to the tail in
  // order; the first sn[X] of them are speculatively allocated.
  int aq0[$];
  int aq1[$];
  int sn[2];
  bit ovf[2];
  int dep[2] = '{64, 63};

  int cur_n, cur_m, cur_c, cur_t0, cur_t1;
  bit cur_rec;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    aq0.delete();
    aq1.delete();
    for (int i = 0; i < 64; i++) aq0.push_back(NUM_AREGS + i);
    for (int i = 0; i < 63; i++) aq1.push_back(NUM_AREGS + i);
    sn  = '{0, 0};
    ovf = '{0, 0};
  endtask

  task automatic model_update(input int d);
    int q[$];
    int sz0, cnt, ng, a;
    if (d == 0) q = aq0; else q = aq1;
    sz0 = q.size();
    cnt = sz0 - sn[d];
    ng  = (!cur_rec && cur_n <= cnt) ? cur_n : 0;
    if ((cnt + cur_m - ng > dep[d]) || (sz0 + cur_m - cur_c > dep[d])) ovf[d] = 1'b1;
    for (int k = 0; k < cur_c; k++) void'(q.pop_front());
    sn[d] -= cur_c;
    a = cur_m;
    if (a > dep[d] - q.size()) a = dep[d] - q.size();
    if (a > 0) q.push_back(cur_t0);
    if (a > 1) q.push_back(cur_t1);
    if (cur_rec) sn[d] = 0; else sn[d] += ng;
    if (d == 0) aq0 = q; else aq1 = q;
  endtask

  task automatic check_dut(input int d);
    int q[$];
    int cnt;
    bit eg;
    logic [WIDTH*TAG_W-1:0] epr, pr;
    logic [WIDTH-1:0]       ev, v;
    logic [7:0]             fc;
    logic                   g, o;
    string p;
    if (d == 0) begin
      q = aq0; p = "a";
      g = ifa.fl_grant; pr = ifa.fl_pr; v = ifa.fl_pr_valid;
      fc = 8'(ifa.fl_free_count); o = ifa.fl_overflow;
    end else begin
      q = aq1; p = "b";
      g = ifb.fl_grant; pr = ifb.fl_pr; v = ifb.fl_pr_valid;
      fc = 8'(ifb.fl_free_count); o = ifb.fl_overflow;
    end
    cnt = q.size() - sn[d];
    eg  = !cur_rec && (cur_n <= cnt);
    epr = '0;
    ev  = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (eg && k < cur_n) begin
        epr[k*TAG_W +: TAG_W] = TAG_W'(q[sn[d] + k]);
        ev[k] = 1'b1;
      end
    end
    chk({p, "_grant"}, 64'(g), 64'(eg));
    chk({p, "_pr"}, 64'(pr), 64'(epr));
    chk({p, "_valid"}, 64'(v), 64'(ev));
    chk({p, "_count"}, 64'(fc), 64'(cnt));
    chk({p, "_overflow"}, 64'(o), 64'(ovf[d]));
  endtask

  task automatic apply(input int n, input int m, input int t0, input int t1,
                       input int c, input bit rec);
    @(negedge clock);
    cur_n = n; cur_m = m; cur_t0 = t0; cur_t1 = t1; cur_c = c; cur_rec = rec;
    ifa.id_dispatch_num = NUM_W'(n);
    ifa.rob_retire_num  = NUM_W'(m);
    ifa.rob_retire_tags = {TAG_W'(t1), TAG_W'(t0)};
    ifa.rob_commit_num  = NUM_W'(c);
    ifa.rob_recover     = rec;
    ifb.id_dispatch_num = NUM_W'(n);
    ifb.rob_retire_num  = NUM_W'(m);
    ifb.rob_retire_tags = {TAG_W'(t1), TAG_W'(t0)};
    ifb.rob_commit_num  = NUM_W'(c);
    ifb.rob_recover     = rec;
    #1;
    check_dut(0);
    check_dut(1);
  endtask

  task automatic tick();
    @(posedge clock);
    model_update(0);
    model_update(1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    cur_n = 0; cur_m = 0; cur_c = 0; cur_rec = 0;
    ifa.id_dispatch_num = '0; ifa.rob_retire_num = '0; ifa.rob_commit_num = '0; ifa.rob_recover = 1'b0;
    ifb.id_dispatch_num = '0; ifb.rob_retire_num = '0; ifb.rob_commit_num = '0; ifb.rob_recover = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_overflow", 64'(ifa.fl_overflow), 64'd0);
    chk("async_rst_count", 64'(ifa.fl_free_count), 64'd64);
    chk("async_rst_count_b", 64'(ifb.fl_free_count), 64'd63);
    #1 reset = 1'b0;
    model_reset();
  endtask

  initial begin
    #500000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int c, m, room, smin;
    ifa.id_dispatch_num = '0; ifa.rob_retire_num = '0; ifa.rob_retire_tags = '0;
    ifa.rob_commit_num = '0; ifa.rob_recover = 1'b0;
    ifb.id_dispatch_num = '0; ifb.rob_retire_num = '0; ifb.rob_retire_tags = '0;
    ifb.rob_commit_num = '0; ifb.rob_recover = 1'b0;
    model_reset();
    #12 reset = 1'b0;

    // Drain from reset two tags per cycle.
    apply(0, 0, 0, 0, 0, 0);
    chk("reset_count", 64'(ifa.fl_free_count), 64'd64);
    chk("zero_req_grant", 64'(ifa.fl_grant), 64'd1);
    tick();
    for (int i = 0; i < 32; i++) begin
      apply(2, 0, 0, 0, 0, 0);
      chk("drain_pair", 64'(ifa.fl_pr), 64'({TAG_W'(33 + 2*i), TAG_W'(32 + 2*i)}));
      tick();
    end
    apply(2, 0, 0, 0, 0, 0);
    chk("empty_count", 64'(ifa.fl_free_count), 64'd0);
    chk("empty_grant", 64'(ifa.fl_grant), 64'd0);
    chk("empty_valid", 64'(ifa.fl_pr_valid), 64'd0);
    tick();

    // Stall at count=1 while a tag is freed; the retry gets both.
    apply(0, 1, 7, 0, 1, 0);
    tick();
    apply(2, 1, 40, 0, 1, 0);
    chk("stall_grant", 64'(ifa.fl_grant), 64'd0);
    chk("stall_pr", 64'(ifa.fl_pr), 64'd0);
    tick();
    apply(2, 0, 0, 0, 0, 0);
    chk("retry_count", 64'(ifa.fl_free_count), 64'd2);
    chk("retry_pr", 64'(ifa.fl_pr), 64'({TAG_W'(40), TAG_W'(7)}));
    tick();

    // Mispredict recovery.
    do_reset();
    for (int i = 0; i < 3; i++) begin apply(2, 0, 0, 0, 0, 0); tick(); end
    apply(0, 0, 0, 0, 2, 0); tick();
    apply(2, 0, 0, 0, 1, 1);
    chk("recover_grant", 64'(ifa.fl_grant), 64'd0);
    tick();
    apply(1, 0, 0, 0, 0, 0);
    chk("recover_count", 64'(ifa.fl_free_count), 64'd61);
    chk("recover_tag", 64'(ifa.fl_pr), 64'd35);
    tick();

    // Overflow on a full list, sticky until async reset.
    do_reset();
    apply(0, 1, 9, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0);
    chk("ovf_set", 64'(ifa.fl_overflow), 64'd1);
    chk("ovf_count", 64'(ifa.fl_free_count), 64'd64);
    tick();
    apply(2, 0, 0, 0, 0, 0); tick();
    apply(0, 0, 0, 0, 0, 0);
    chk("ovf_sticky", 64'(ifa.fl_overflow), 64'd1);
    tick();
    do_reset();

    // Simultaneous dispatch, retire and commit; freed tags return after wrap.
    apply(2, 0, 0, 0, 0, 0); tick();
    apply(2, 2, 5, 6, 2, 0); tick();
    apply(0, 0, 0, 0, 0, 0);
    chk("same_cycle_count", 64'(ifa.fl_free_count), 64'd62);
    tick();
    for (int i = 0; i < 31; i++) begin
      apply(2, 0, 0, 0, 0, 0);
      if (i == 30) chk("wrapped_retired_tags", 64'(ifa.fl_pr), 64'({TAG_W'(6), TAG_W'(5)}));
      tick();
    end

    // Randomized traffic within ROB guarantees.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      smin = (sn[0] < sn[1]) ? sn[0] : sn[1];
      c = $urandom_range(0, (smin < WIDTH) ? smin : WIDTH);
      room = 64 - (aq0.size() - c);
      if (63 - (aq1.size() - c) < room) room = 63 - (aq1.size() - c);
      m = $urandom_range(0, (room < WIDTH) ? room : WIDTH);
      apply($urandom_range(0, WIDTH), m, $urandom_range(0, 127), $urandom_range(0, 127),
            c, ($urandom_range(0, 19) == 0));
      tick();
    end
    apply(0, 0, 0, 0, 0, 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
